// File: rtl/wbu.sv
// ============================================================================
// Module   : wbu
// Brief    : Write-back/commit stage: GPR/CSR writes, ecall trap, next-PC handoff.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wbu #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342,
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in_lsu,
    output logic        ready_out_lsu,
    input  logic        ben,
    input  logic [31:0] pc,
    input  logic [31:0] csr_out,
    input  logic [6:0]  opcode,
    input  logic        gpr_wen,
    input  logic [4:0]  rd,
    input  logic        csr_wen,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic [31:0] alu_out,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic [1:0]  bresp,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        gpr_we_o,
    output logic [4:0]  gpr_waddr_o,
    output logic [31:0] gpr_wdata_o,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic [31:0] npc,
    output logic        valid_out_ifu,
    input  logic        ready_in_ifu,
    output logic        commit,
    output logic        bus_err
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_TRAP   = 2'd2,
        S_SEND   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_ben;
    logic [31:0] r_pc;
    logic [31:0] r_csr_out;
    logic [6:0]  r_opcode;
    logic        r_gpr_wen;
    logic [4:0]  r_rd;
    logic        r_csr_wen;
    logic [11:0] r_csr_waddr;
    logic [31:0] r_csr_wdata;
    logic        r_is_ecall;
    logic        r_is_mret;
    logic [31:0] r_alu_out;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [1:0]  r_bresp;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_npc;
    logic        r_bus_err;

    logic [31:0] w_seq_pc;
    logic        w_is_load;
    logic        w_load_fault;
    logic        w_bus_fault;
    logic [31:0] w_wdata;
    logic [31:0] w_npc;

    assign w_seq_pc     = r_pc + 32'd4;
    assign w_is_load    = (r_opcode == c_OP_LOAD);
    assign w_load_fault = w_is_load && (r_rresp != 2'b00);
    assign w_bus_fault  = w_load_fault ||
                          ((r_opcode == c_OP_STORE) && (r_bresp != 2'b00));

    always_comb begin
        w_wdata = r_alu_out;
        case (r_opcode)
            c_OP_LOAD:           w_wdata = r_rdata;
            c_OP_JAL, c_OP_JALR: w_wdata = w_seq_pc;
            c_OP_SYSTEM:         w_wdata = r_csr_out;
            default:             w_wdata = r_alu_out;
        endcase
    end

    // Trap entry/return take precedence over any control-flow opcode.
    always_comb begin
        w_npc = w_seq_pc;
        if (r_is_ecall) begin
            w_npc = r_mtvec;
        end else if (r_is_mret) begin
            w_npc = r_mepc;
        end else begin
            case (r_opcode)
                c_OP_JAL:    w_npc = r_alu_out;
                c_OP_JALR:   w_npc = r_alu_out & ~32'd1;
                c_OP_BRANCH: w_npc = r_ben ? r_alu_out : w_seq_pc;
                default:     w_npc = w_seq_pc;
            endcase
        end
    end

    assign gpr_waddr_o = r_rd;
    assign gpr_wdata_o = w_wdata;
    assign npc         = r_npc;
    assign bus_err     = r_bus_err;

    always_comb begin
        w_next        = r_state;
        ready_out_lsu = 1'b0;
        commit        = 1'b0;
        gpr_we_o      = 1'b0;
        csr_we_o      = 1'b0;
        csr_waddr_o   = r_is_ecall ? CSR_MEPC : r_csr_waddr;
        csr_wdata_o   = r_is_ecall ? r_pc     : r_csr_wdata;
        valid_out_ifu = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_out_lsu = 1'b1;
                if (valid_in_lsu) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit   = 1'b1;
                gpr_we_o = r_gpr_wen && (r_rd != 5'd0) && !w_load_fault;
                csr_we_o = r_is_ecall || r_csr_wen;
                w_next   = r_is_ecall ? S_TRAP : S_SEND;
            end
            S_TRAP: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = ECALL_CAUSE;
                w_next      = S_SEND;
            end
            S_SEND: begin
                valid_out_ifu = 1'b1;
                if (ready_in_ifu) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ben       <= 1'b0;
            r_pc        <= 32'd0;
            r_csr_out   <= 32'd0;
            r_opcode    <= 7'd0;
            r_gpr_wen   <= 1'b0;
            r_rd        <= 5'd0;
            r_csr_wen   <= 1'b0;
            r_csr_waddr <= 12'd0;
            r_csr_wdata <= 32'd0;
            r_is_ecall  <= 1'b0;
            r_is_mret   <= 1'b0;
            r_alu_out   <= 32'd0;
            r_rdata     <= 32'd0;
            r_rresp     <= 2'd0;
            r_bresp     <= 2'd0;
            r_mtvec     <= 32'd0;
            r_mepc      <= 32'd0;
            r_npc       <= RESET_PC;
            r_bus_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && valid_in_lsu) begin
                r_ben       <= ben;
                r_pc        <= pc;
                r_csr_out   <= csr_out;
                r_opcode    <= opcode;
                r_gpr_wen   <= gpr_wen;
                r_rd        <= rd;
                r_csr_wen   <= csr_wen;
                r_csr_waddr <= csr_waddr;
                r_csr_wdata <= csr_wdata;
                r_is_ecall  <= is_ecall;
                r_is_mret   <= is_mret;
                r_alu_out   <= alu_out;
                r_rdata     <= rdata;
                r_rresp     <= rresp;
                r_bresp     <= bresp;
                r_mtvec     <= mtvec;
                r_mepc      <= mepc;
            end
            if (r_state == S_COMMIT) begin
                r_npc <= w_npc;
                if (w_bus_fault) begin
                    r_bus_err <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wbu.sv
// ============================================================================
// Module   : tb_wbu
// Brief    : Self-checking bench for wbu against a transaction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wbu;

    typedef struct packed {
        logic        ben;
        logic [31:0] pc;
        logic [31:0] csr_out;
        logic [6:0]  opcode;
        logic        gpr_wen;
        logic [4:0]  rd;
        logic        csr_wen;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
        logic        is_ecall;
        logic        is_mret;
        logic [31:0] alu_out;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        logic [31:0] mtvec;
        logic [31:0] mepc;
    } txn_t;

    typedef struct packed {
        logic        gpr_we;
        logic [4:0]  gpr_waddr;
        logic [31:0] gpr_wdata;
        logic        csr_we;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
        logic [31:0] npc;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in_lsu = 1'b0;
    logic        ready_out_lsu;
    logic        ben = 1'b0;
    logic [31:0] pc = '0, csr_out = '0, alu_out = '0, rdata = '0, mtvec = '0, mepc = '0;
    logic [31:0] csr_wdata = '0;
    logic [6:0]  opcode = '0;
    logic        gpr_wen = 1'b0, csr_wen = 1'b0, is_ecall = 1'b0, is_mret = 1'b0;
    logic [4:0]  rd = '0;
    logic [11:0] csr_waddr = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic        gpr_we_o, csr_we_o, valid_out_ifu, commit, bus_err;
    logic [4:0]  gpr_waddr_o;
    logic [31:0] gpr_wdata_o, csr_wdata_o, npc;
    logic [11:0] csr_waddr_o;
    logic        ready_in_ifu = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    logic m_berr = 1'b0;

    always #5 clk = ~clk;

    wbu dut (
        .clk(clk), .rst(rst),
        .valid_in_lsu(valid_in_lsu), .ready_out_lsu(ready_out_lsu),
        .ben(ben), .pc(pc), .csr_out(csr_out), .opcode(opcode),
        .gpr_wen(gpr_wen), .rd(rd),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .is_ecall(is_ecall), .is_mret(is_mret),
        .alu_out(alu_out), .rdata(rdata), .rresp(rresp), .bresp(bresp),
        .mtvec(mtvec), .mepc(mepc),
        .gpr_we_o(gpr_we_o), .gpr_waddr_o(gpr_waddr_o), .gpr_wdata_o(gpr_wdata_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .npc(npc), .valid_out_ifu(valid_out_ifu), .ready_in_ifu(ready_in_ifu),
        .commit(commit), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Architectural outcome of retiring one instruction.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        logic [31:0] nxt;
        logic load, store;
        nxt   = t.pc + 32'd4;
        load  = (t.opcode == 7'b0000011);
        store = (t.opcode == 7'b0100011);
        e.fault     = (load && t.rresp != 0) || (store && t.bresp != 0);
        e.gpr_we    = t.gpr_wen && (t.rd != 0) && !(load && t.rresp != 0);
        e.gpr_waddr = t.rd;
        if (load)                                               e.gpr_wdata = t.rdata;
        else if (t.opcode == 7'b1101111 || t.opcode == 7'b1100111) e.gpr_wdata = nxt;
        else if (t.opcode == 7'b1110011)                         e.gpr_wdata = t.csr_out;
        else                                                     e.gpr_wdata = t.alu_out;
        e.csr_we    = t.is_ecall || t.csr_wen;
        e.csr_waddr = t.is_ecall ? 12'h341 : t.csr_waddr;
        e.csr_wdata = t.is_ecall ? t.pc : t.csr_wdata;
        if (t.is_ecall)                  e.npc = t.mtvec;
        else if (t.is_mret)              e.npc = t.mepc;
        else if (t.opcode == 7'b1101111) e.npc = t.alu_out;
        else if (t.opcode == 7'b1100111) e.npc = {t.alu_out[31:1], 1'b0};
        else if (t.opcode == 7'b1100011) e.npc = t.ben ? t.alu_out : nxt;
        else                             e.npc = nxt;
        return e;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111,
                                7'b1100011, 7'b1110011, 7'b0010011, 7'b0110011};
        int sel;
        t = txn_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom});
        t.opcode   = ops[$urandom_range(0, 7)];
        sel        = $urandom_range(0, 9);
        t.is_ecall = (sel == 0);
        t.is_mret  = (sel == 1);
        if (sel <= 1) t.opcode = 7'b1110011;
        t.rresp    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        t.bresp    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if ($urandom_range(0, 7) == 0) t.pc = 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) t.rd = 5'd0;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        ben = t.ben; pc = t.pc; csr_out = t.csr_out; opcode = t.opcode;
        gpr_wen = t.gpr_wen; rd = t.rd; csr_wen = t.csr_wen;
        csr_waddr = t.csr_waddr; csr_wdata = t.csr_wdata;
        is_ecall = t.is_ecall; is_mret = t.is_mret; alu_out = t.alu_out;
        rdata = t.rdata; rresp = t.rresp; bresp = t.bresp; mtvec = t.mtvec; mepc = t.mepc;
    endtask

    task automatic do_reset();
        rst = 1'b0; valid_in_lsu = 1'b0; ready_in_ifu = 1'b0;
        repeat (2) @(negedge clk);
        m_berr = 1'b0;
        chk("rst_npc", npc, 32'h8000_0000);
        chk("rst_ready", ready_out_lsu, 1);
        chk("rst_gpr_we", gpr_we_o, 0);
        chk("rst_csr_we", csr_we_o, 0);
        chk("rst_commit", commit, 0);
        chk("rst_valid", valid_out_ifu, 0);
        chk("rst_bus_err", bus_err, 0);
        rst = 1'b1;
    endtask

    // One instruction end to end; abort=1 resets while npc is pending.
    task automatic run_txn(input txn_t t, input int stall, input bit abort);
        exp_t e;
        e = model(t);
        chk("idle_ready", ready_out_lsu, 1);
        drive(t);
        valid_in_lsu = 1'b1;
        @(negedge clk);
        valid_in_lsu = 1'b0;
        drive(rand_txn());
        chk("commit", commit, 1);
        chk("busy_ready", ready_out_lsu, 0);
        chk("early_valid", valid_out_ifu, 0);
        chk("gpr_we", gpr_we_o, e.gpr_we);
        if (e.gpr_we) begin
            chk("gpr_waddr", gpr_waddr_o, e.gpr_waddr);
            chk("gpr_wdata", gpr_wdata_o, e.gpr_wdata);
        end
        chk("csr_we", csr_we_o, e.csr_we);
        if (e.csr_we) begin
            chk("csr_waddr", csr_waddr_o, e.csr_waddr);
            chk("csr_wdata", csr_wdata_o, e.csr_wdata);
        end
        if (e.fault) m_berr = 1'b1;
        @(negedge clk);
        if (t.is_ecall) begin
            chk("trap_we", csr_we_o, 1);
            chk("trap_waddr", csr_waddr_o, 32'h342);
            chk("trap_wdata", csr_wdata_o, 32'd11);
            chk("trap_commit", commit, 0);
            chk("trap_gpr_we", gpr_we_o, 0);
            chk("trap_valid", valid_out_ifu, 0);
            @(negedge clk);
        end
        chk("send_valid", valid_out_ifu, 1);
        chk("send_npc", npc, e.npc);
        chk("send_commit", commit, 0);
        chk("send_gpr_we", gpr_we_o, 0);
        chk("send_csr_we", csr_we_o, 0);
        chk("send_ready", ready_out_lsu, 0);
        chk("bus_err", bus_err, m_berr);
        if (abort) begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            m_berr = 1'b0;
            chk("abort_valid", valid_out_ifu, 0);
            chk("abort_npc", npc, 32'h8000_0000);
            chk("abort_commit", commit, 0);
            chk("abort_bus_err", bus_err, 0);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", valid_out_ifu, 1);
            chk("hold_npc", npc, e.npc);
            chk("hold_ready", ready_out_lsu, 0);
            chk("hold_commit", commit, 0);
        end
        ready_in_ifu = 1'b1;
        @(negedge clk);
        ready_in_ifu = 1'b0;
        chk("done_valid", valid_out_ifu, 0);
        chk("done_ready", ready_out_lsu, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        @(negedge clk);
        do_reset();

        t = '0; t.opcode = 7'b0010011; t.gpr_wen = 1; t.rd = 5;
        t.alu_out = 32'h1234; t.pc = 32'h8000_0000;
        run_txn(t, 3, 0);
        t.rd = 0;
        run_txn(t, 0, 0);

        t = '0; t.opcode = 7'b0000011; t.gpr_wen = 1; t.rd = 7;
        t.rresp = 2'b10; t.rdata = 32'hDEAD_BEEF; t.pc = 32'h8000_0008;
        run_txn(t, 1, 0);
        t = '0; t.opcode = 7'b1100111; t.gpr_wen = 1; t.rd = 1;
        t.pc = 32'h8000_0010; t.alu_out = 32'h8000_0101;
        run_txn(t, 0, 0);

        t = '0; t.opcode = 7'b1110011; t.is_ecall = 1; t.csr_wen = 1;
        t.csr_waddr = 12'h300; t.csr_wdata = 32'h55; t.pc = 32'h8000_0020;
        t.mtvec = 32'h8000_1000;
        run_txn(t, 1, 0);
        t = '0; t.opcode = 7'b1110011; t.is_mret = 1; t.mepc = 32'h8000_0024;
        run_txn(t, 0, 0);

        t = '0; t.opcode = 7'b1100011; t.pc = 32'h8000_0040; t.alu_out = 32'h8000_0200;
        run_txn(t, 0, 0);
        t.ben = 1;
        run_txn(t, 5, 0);

        t = '0; t.opcode = 7'b1101111; t.gpr_wen = 1; t.rd = 1; t.pc = 32'hFFFF_FFFC;
        t.alu_out = 32'h8000_0300;
        run_txn(t, 0, 0);

        t = '0; t.opcode = 7'b0010011; t.gpr_wen = 1; t.rd = 3; t.pc = 32'h8000_0050;
        run_txn(t, 0, 1);

        do_reset();
        for (int k = 0; k < 240; k++) begin
            if (k % 60 == 59) do_reset();
            run_txn(rand_txn(), $urandom_range(0, 3), ($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wbu.md
Name: wbu

Overview:
- Write-back/commit stage directly downstream of the load-store stage.
- Accepts one retiring instruction per valid/ready handshake from the LSU.
- Performs the single-cycle GPR and CSR writes and handles ecall's two-step CSR update.
- Computes the next PC and hands it to the IFU over a valid/ready handshake; closes the IFU-EXU-LSU-WBU loop (one instruction in flight).

Parameters:
RESET_PC, 32'h8000_0000, value of npc after reset
CSR_MEPC, 12'h341, CSR address written with pc on ecall
CSR_MCAUSE, 12'h342, CSR address written with cause on ecall
ECALL_CAUSE, 32'd11, mcause value for ecall from M-mode

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-low reset (0 = reset, sampled on rising edge of clk)
valid_in_lsu  in  1  LSU has an instruction to commit
ready_out_lsu  out  1  WBU can accept
ben, pc, csr_out, opcode  in  1/32/32/7  branch taken, inst pc, CSR read value, opcode
gpr_wen, rd  in  1/5  GPR write request, destination
csr_wen, csr_waddr, csr_wdata  in  1/12/32  CSR write request
is_ecall, is_mret  in  1/1  trap flags
alu_out  in  32  ALU result; jump/branch target for JAL/JALR/BRANCH
rdata  in  32  extended load data
rresp, bresp  in  2/2  AXI responses of last load/store
mtvec, mepc  in  32/32  current CSR values from CSR file
gpr_we_o, gpr_waddr_o, gpr_wdata_o  out  1/5/32  GPR write port
csr_we_o, csr_waddr_o, csr_wdata_o  out  1/12/32  CSR write port
npc  out  32  next PC
valid_out_ifu  out  1  npc valid
ready_in_ifu  in  1  IFU accepts npc
commit  out  1  one-cycle retire pulse
bus_err  out  1  sticky: a load/store returned non-OKAY

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, npc=RESET_PC, valid_out_ifu=0, gpr_we_o=0, csr_we_o=0, commit=0, bus_err=0; all latched input fields cleared to 0. Reset mid-operation aborts any pending write or pending npc; nothing is written.
- States: IDLE, COMMIT, TRAP, SEND.
- IDLE: ready_out_lsu=1. On valid_in_lsu: latch all inputs, go to COMMIT. Only the IDLE state asserts ready.
- COMMIT (one cycle):
  - commit=1.
  - wdata select by latched opcode: 0000011 -> rdata; 1101111/1100111 -> pc+4; 1110011 -> csr_out; else alu_out.
  - gpr_we_o = gpr_wen && rd!=0 && !(load && rresp!=0).
  - CSR write: if is_ecall, write CSR_MEPC<=pc. Else if csr_wen, write csr_waddr<=csr_wdata. ecall overrides csr_wen.
  - bus_err set if (load && rresp!=0) or (store opcode 0100011 && bresp!=0).
  - npc rules, in priority order:
    - is_ecall: mtvec
    - is_mret: mepc
    - JAL: alu_out
    - JALR: alu_out & ~1
    - BRANCH (1100011): ben ? alu_out : pc+4
    - otherwise: pc+4
  - npc is registered at end of COMMIT. Next state is TRAP if is_ecall, else SEND.
- TRAP (one cycle): csr_we_o=1, CSR_MCAUSE<=ECALL_CAUSE; go to SEND.
- SEND: valid_out_ifu=1, npc stable. Leave to IDLE on the cycle ready_in_ifu=1. Hold indefinitely otherwise.
- Write ports and commit are asserted only in COMMIT (and csr in TRAP). Exactly one cycle per instruction.
- Latency: handshake at edge N -> COMMIT N..N+1 -> valid_out_ifu from N+1 (N+2 for ecall). Min 3 cycles from accept to next ready.
- Arithmetic: pc+4 is 32-bit wrapping (32'hFFFF_FFFC+4=0).
- Inputs other than handshakes are ignored outside IDLE.

Test Plan:
- Reset: hold rst=0 two cycles -> npc=0x8000_0000, ready_out_lsu=1, all write enables 0, bus_err=0.
- ADDI x5, alu_out=0x1234, pc=0x8000_0000 -> one-cycle gpr_we_o, waddr=5, wdata=0x1234; npc=0x8000_0004 held until ready_in_ifu. Repeat with rd=0 -> gpr_we_o stays 0.
- Load with rresp=2'b10 -> gpr_we_o=0, bus_err=1 and stays 1. JALR pc=0x8000_0010, alu_out=0x8000_0101 -> wdata=0x8000_0014, npc=0x8000_0100.
- ecall pc=0x8000_0020, mtvec=0x8000_1000 -> COMMIT writes 0x341<=0x8000_0020, TRAP writes 0x342<=11, then npc=0x8000_1000. mret, mepc=0x8000_0024 -> npc=0x8000_0024, no CSR write.
- Branch with ben=0 and with ben=1, alu_out=0x8000_0200 -> npc=pc+4 vs 0x8000_0200. ready_in_ifu low 5 cycles -> valid_out_ifu and npc held, ready_out_lsu=0 throughout.
- Assert rst=0 during SEND -> no commit, valid_out_ifu=0 next cycle, npc=RESET_PC.
